// File: rtl/zx_vram_arbiter.sv
// zx_vram_arbiter
//
// Time-shares the single 512K x 8 video/system SRAM between three requesters:
// ULA screen fetch (video), CPU and an optional DMA/loader port. Each access is
// a two-cycle sequence (P0, P1) on clk28. Arbitration runs in IDLE and at the end
// of P1, so back-to-back accesses sustain one access every two cycles.
// Priority is video > cpu > dma. A starvation guard lets the CPU beat video once
// after CPU_MAX_WAIT consecutive lost arbitrations (0 disables the guard).
//
// Optional feature macro: ZX_VRAM_ARB_DMA_EN
//   defined   - dma_* joins arbitration at the lowest priority
//   undefined - dma_req is ignored, dma_ack/dma_valid/dma_rdata are held at 0
//
// Ports:
//   clk28, rst                          clock, synchronous active-high reset
//   video_req/addr -> video_ack/valid/data
//                                       screen fetch (always a read)
//   cpu_req/wr/addr/wdata -> cpu_ack/valid/rdata
//                                       CPU access
//   dma_req/wr/addr/wdata -> dma_ack/valid/rdata
//                                       DMA access (same semantics as CPU)
//   va, vd_o, vd_oe, vd_i, n_vrd, n_vwr SRAM pins (strobes active-low)
//
// Handshake: a requester holds req/addr/wr/wdata until its ack pulse. Ack is
// high during P0; read data arrives with a one-cycle valid pulse on the cycle
// after P1 and rdata holds until that requester's next read.

module zx_vram_arbiter #(
    parameter int unsigned CPU_MAX_WAIT = 3
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        video_req,
    input  logic [18:0] video_addr,
    output logic        video_ack,
    output logic        video_valid,
    output logic [7:0]  video_data,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_valid,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [18:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic        dma_valid,
    output logic [7:0]  dma_rdata,
    output logic [18:0] va,
    output logic [7:0]  vd_o,
    output logic        vd_oe,
    input  logic [7:0]  vd_i,
    output logic        n_vrd,
    output logic        n_vwr
);

    typedef enum logic [1:0] {IDLE, P0, P1} state_t;
    typedef enum logic [1:0] {OWN_VIDEO, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [18:0] va_q, va_d;
    logic [7:0]  vd_o_q, vd_o_d;
    logic        vd_oe_q, vd_oe_d;
    logic        n_vrd_q, n_vrd_d;
    logic        n_vwr_q, n_vwr_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;

    logic        video_ack_q, video_ack_d;
    logic        video_valid_q, video_valid_d;
    logic [7:0]  video_data_q, video_data_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_valid_q, cpu_valid_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;

    logic        arb_en;
    logic        cpu_boost;
    logic        gnt_video;
    logic        gnt_cpu;
    logic        gnt_any;

`ifdef ZX_VRAM_ARB_DMA_EN
    logic        gnt_dma;
    logic        dma_ack_q, dma_ack_d;
    logic        dma_valid_q, dma_valid_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;
`else
    // DMA inputs are kept only for pin compatibility in this build.
    logic        unused_dma;
    assign unused_dma = ^{dma_req, dma_wr, dma_addr, dma_wdata};
`endif

    assign arb_en    = (state_q == IDLE) || (state_q == P1);
    // A CPU that has lost MAX_WAIT arbitrations to video in a row wins this one.
    assign cpu_boost = (MAX_WAIT != 4'd0) && (wait_cnt_q == MAX_WAIT) && cpu_req;

    always_comb begin
        gnt_video = 1'b0;
        gnt_cpu   = 1'b0;
`ifdef ZX_VRAM_ARB_DMA_EN
        gnt_dma   = 1'b0;
`endif
        if (cpu_boost) begin
            gnt_cpu = 1'b1;
        end else if (video_req) begin
            gnt_video = 1'b1;
        end else if (cpu_req) begin
            gnt_cpu = 1'b1;
`ifdef ZX_VRAM_ARB_DMA_EN
        end else if (dma_req) begin
            gnt_dma = 1'b1;
`endif
        end
    end

`ifdef ZX_VRAM_ARB_DMA_EN
    assign gnt_any = gnt_video | gnt_cpu | gnt_dma;
`else
    assign gnt_any = gnt_video | gnt_cpu;
`endif

    // The strobe registers hold the pin values for the state being entered.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        va_d          = va_q;
        vd_o_d        = vd_o_q;
        vd_oe_d       = 1'b0;
        n_vrd_d       = 1'b1;
        n_vwr_d       = 1'b1;
        wait_cnt_d    = wait_cnt_q;
        video_ack_d   = 1'b0;
        video_valid_d = 1'b0;
        video_data_d  = video_data_q;
        cpu_ack_d     = 1'b0;
        cpu_valid_d   = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
`ifdef ZX_VRAM_ARB_DMA_EN
        dma_ack_d     = 1'b0;
        dma_valid_d   = 1'b0;
        dma_rdata_d   = dma_rdata_q;
`endif

        case (state_q)
            P0: begin
                state_d = P1;
                if (wr_q) begin
                    vd_oe_d = 1'b1;
                    n_vwr_d = 1'b0;
                end else begin
                    n_vrd_d = 1'b0;
                end
            end
            P1: begin
                // vd_i is sampled on the edge that ends P1.
                if (!wr_q) begin
                    case (owner_q)
                        OWN_VIDEO: begin
                            video_valid_d = 1'b1;
                            video_data_d  = vd_i;
                        end
                        OWN_CPU: begin
                            cpu_valid_d = 1'b1;
                            cpu_rdata_d = vd_i;
                        end
`ifdef ZX_VRAM_ARB_DMA_EN
                        OWN_DMA: begin
                            dma_valid_d = 1'b1;
                            dma_rdata_d = vd_i;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase

        if (arb_en) begin
            state_d = IDLE;
            if (gnt_cpu) begin
                wait_cnt_d = 4'd0;
            end else if (gnt_video && cpu_req && (wait_cnt_q != 4'd15)) begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end

            if (gnt_video) begin
                owner_d     = OWN_VIDEO;
                wr_d        = 1'b0;
                va_d        = video_addr;
                video_ack_d = 1'b1;
            end else if (gnt_cpu) begin
                owner_d   = OWN_CPU;
                wr_d      = cpu_wr;
                va_d      = cpu_addr;
                cpu_ack_d = 1'b1;
                if (cpu_wr) begin
                    vd_o_d = cpu_wdata;
                end
`ifdef ZX_VRAM_ARB_DMA_EN
            end else if (gnt_dma) begin
                owner_d   = OWN_DMA;
                wr_d      = dma_wr;
                va_d      = dma_addr;
                dma_ack_d = 1'b1;
                if (dma_wr) begin
                    vd_o_d = dma_wdata;
                end
`endif
            end

            if (gnt_any) begin
                state_d = P0;
                if (wr_d) begin
                    vd_oe_d = 1'b1;
                end else begin
                    n_vrd_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_VIDEO;
            wr_q          <= 1'b0;
            va_q          <= '0;
            vd_o_q        <= '0;
            vd_oe_q       <= 1'b0;
            n_vrd_q       <= 1'b1;
            n_vwr_q       <= 1'b1;
            wait_cnt_q    <= '0;
            video_ack_q   <= 1'b0;
            video_valid_q <= 1'b0;
            video_data_q  <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_valid_q   <= 1'b0;
            cpu_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            va_q          <= va_d;
            vd_o_q        <= vd_o_d;
            vd_oe_q       <= vd_oe_d;
            n_vrd_q       <= n_vrd_d;
            n_vwr_q       <= n_vwr_d;
            wait_cnt_q    <= wait_cnt_d;
            video_ack_q   <= video_ack_d;
            video_valid_q <= video_valid_d;
            video_data_q  <= video_data_d;
            cpu_ack_q     <= cpu_ack_d;
            cpu_valid_q   <= cpu_valid_d;
            cpu_rdata_q   <= cpu_rdata_d;
        end
    end

`ifdef ZX_VRAM_ARB_DMA_EN
    always_ff @(posedge clk28) begin
        if (rst) begin
            dma_ack_q   <= 1'b0;
            dma_valid_q <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            dma_ack_q   <= dma_ack_d;
            dma_valid_q <= dma_valid_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign dma_ack   = dma_ack_q;
    assign dma_valid = dma_valid_q;
    assign dma_rdata = dma_rdata_q;
`else
    assign dma_ack   = 1'b0;
    assign dma_valid = 1'b0;
    assign dma_rdata = 8'h00;
`endif

    assign va          = va_q;
    assign vd_o        = vd_o_q;
    assign vd_oe       = vd_oe_q;
    assign n_vrd       = n_vrd_q;
    assign n_vwr       = n_vwr_q;
    assign video_ack   = video_ack_q;
    assign video_valid = video_valid_q;
    assign video_data  = video_data_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_valid   = cpu_valid_q;
    assign cpu_rdata   = cpu_rdata_q;

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Testbench for zx_vram_arbiter: an SRAM model behind DUT "dut" (CPU_MAX_WAIT=3)
// and a second instance "dut_b" (CPU_MAX_WAIT=0) for pure fixed priority.
// Expected grants and read bytes are queued when requests are driven and
// consumed by a monitor when the DUT acknowledges or returns data.
`timescale 1ns/1ps

module tb_zx_vram_arbiter;

    logic        clk28;
    logic        rst;
    logic        video_req;
    logic [18:0] video_addr;
    logic        video_ack, video_valid;
    logic [7:0]  video_data;
    logic        cpu_req, cpu_wr;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack, cpu_valid;
    logic [7:0]  cpu_rdata;
    logic        dma_req, dma_wr;
    logic [18:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack, dma_valid;
    logic [7:0]  dma_rdata;
    logic [18:0] va;
    logic [7:0]  vd_o;
    logic        vd_oe;
    logic [7:0]  vd_i;
    logic        n_vrd, n_vwr;

    logic        b_video_req, b_cpu_req;
    logic        b_video_ack, b_video_valid, b_cpu_ack, b_cpu_valid;
    logic        b_dma_ack, b_dma_valid, b_vd_oe, b_n_vrd, b_n_vwr;
    logic [7:0]  b_video_data, b_cpu_rdata, b_dma_rdata, b_vd_o;
    logic [18:0] b_va;

    logic [7:0]  mem [0:255];

    int n_checks = 0;
    int n_errors = 0;
    int rd_lo = 0;
    int wr_lo = 0;

    int        gq[$];
    logic [7:0] vq[$];
    logic [7:0] cq[$];
    logic [7:0] dq[$];

    localparam int G_VID = 1;
    localparam int G_CPU = 2;
    localparam int G_DMA = 4;

    initial clk28 = 1'b0;
    always #18 clk28 = ~clk28;

    zx_vram_arbiter #(.CPU_MAX_WAIT(3)) dut (
        .clk28(clk28), .rst(rst),
        .video_req(video_req), .video_addr(video_addr),
        .video_ack(video_ack), .video_valid(video_valid), .video_data(video_data),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_valid(dma_valid), .dma_rdata(dma_rdata),
        .va(va), .vd_o(vd_o), .vd_oe(vd_oe), .vd_i(vd_i),
        .n_vrd(n_vrd), .n_vwr(n_vwr)
    );

    zx_vram_arbiter #(.CPU_MAX_WAIT(0)) dut_b (
        .clk28(clk28), .rst(rst),
        .video_req(b_video_req), .video_addr(19'h00100),
        .video_ack(b_video_ack), .video_valid(b_video_valid), .video_data(b_video_data),
        .cpu_req(b_cpu_req), .cpu_wr(1'b0), .cpu_addr(19'h00200), .cpu_wdata(8'h00),
        .cpu_ack(b_cpu_ack), .cpu_valid(b_cpu_valid), .cpu_rdata(b_cpu_rdata),
        .dma_req(1'b0), .dma_wr(1'b0), .dma_addr(19'h00000), .dma_wdata(8'h00),
        .dma_ack(b_dma_ack), .dma_valid(b_dma_valid), .dma_rdata(b_dma_rdata),
        .va(b_va), .vd_o(b_vd_o), .vd_oe(b_vd_oe), .vd_i(8'h00),
        .n_vrd(b_n_vrd), .n_vwr(b_n_vwr)
    );

    function automatic logic [7:0] pat(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // SRAM model: 256 bytes aliased over the address space, refilled on reset.
    always @(posedge clk28) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        end else if (!n_vwr) begin
            mem[va[7:0]] <= vd_o;
        end
    end

    assign vd_i = n_vrd ? 8'hEE : mem[va[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: strobe accounting, grant order and read data scoreboard.
    always @(negedge clk28) begin
        int code;
        if (!rst) begin
            if (!n_vrd) rd_lo++;
            if (!n_vwr) begin
                wr_lo++;
                check("vd_oe_during_wr", vd_oe, 1);
            end
            check("rd_wr_exclusive", n_vrd | n_vwr, 1);
            code = {29'd0, dma_ack, cpu_ack, video_ack};
            if (code != 0) begin
                if (gq.size() == 0) check("grant_unexpected", code, 0);
                else check("grant_order", code, gq.pop_front());
            end
            if (video_valid) begin
                if (vq.size() == 0) check("video_valid_unexpected", video_valid, 0);
                else check("video_data", video_data, vq.pop_front());
            end
            if (cpu_valid) begin
                if (cq.size() == 0) check("cpu_valid_unexpected", cpu_valid, 0);
                else check("cpu_rdata", cpu_rdata, cq.pop_front());
            end
            if (dma_valid) begin
                if (dq.size() == 0) check("dma_valid_unexpected", dma_valid, 0);
                else check("dma_rdata", dma_rdata, dq.pop_front());
            end
        end
    end

    initial begin
        #(36 * 20000);
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int wr0, rd0, ngr, last, cyc, nv, nc, nd, cpu_at, dma_at, got;
        rst = 1'b1;
        video_req = 0; video_addr = '0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
        b_video_req = 0; b_cpu_req = 0;
        repeat (3) @(negedge clk28);

        check("rst_va", va, 0);
        check("rst_vd_o", vd_o, 0);
        check("rst_strobes", {n_vrd, n_vwr, vd_oe}, 3'b110);
        check("rst_ack_valid", {video_ack, cpu_ack, dma_ack, video_valid, cpu_valid, dma_valid}, 0);
        check("rst_rdata", {video_data, cpu_rdata, dma_rdata}, 0);
        rst = 1'b0;
        @(negedge clk28);
        check("idle_strobes", {n_vrd, n_vwr, vd_oe}, 3'b110);

        // CPU write 0xA5 -> 0x12345
        wr0 = wr_lo;
        cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h12345; cpu_wdata = 8'hA5;
        gq.push_back(G_CPU);
        @(negedge clk28);
        check("wr_ack", cpu_ack, 1);
        check("wr_va", va, 19'h12345);
        check("wr_vd_o", vd_o, 8'hA5);
        check("wr_p0_strobes", {n_vrd, n_vwr, vd_oe}, 3'b111);
        cpu_req = 0;
        @(negedge clk28);
        check("wr_p1_strobes", {n_vrd, n_vwr, vd_oe}, 3'b101);
        check("wr_ack_pulse", cpu_ack, 0);
        @(negedge clk28);
        check("wr_idle_strobes", {n_vrd, n_vwr, vd_oe}, 3'b110);
        check("wr_va_hold", va, 19'h12345);
        @(negedge clk28);
        check("wr_strobe_count", wr_lo - wr0, 1);

        // CPU read back 0x12345
        rd0 = rd_lo;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h12345;
        gq.push_back(G_CPU); cq.push_back(8'hA5);
        @(negedge clk28);
        check("rd_ack", cpu_ack, 1);
        check("rd_p0_nvrd", n_vrd, 0);
        cpu_req = 0;
        @(negedge clk28);
        check("rd_p1_nvrd", n_vrd, 0);
        @(negedge clk28);
        check("rd_valid", cpu_valid, 1);
        check("rd_release", n_vrd, 1);
        @(negedge clk28);
        check("rd_valid_pulse", cpu_valid, 0);
        check("rd_rdata_hold", cpu_rdata, 8'hA5);
        check("rd_strobe_count", rd_lo - rd0, 2);

        // Video and CPU held high: V,V,V,C,V,V,V,C
        video_addr = 19'h00010; cpu_addr = 19'h00020; cpu_wr = 0;
        video_req = 1; cpu_req = 1;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                gq.push_back(G_VID); vq.push_back(pat(8'h10));
            end
            gq.push_back(G_CPU); cq.push_back(pat(8'h20));
        end
        ngr = 0; last = 0; cyc = 0;
        while (ngr < 8 && cyc < 40) begin
            @(negedge clk28);
            cyc++;
            if (video_ack || cpu_ack) begin
                if (ngr > 0) check("grant_spacing", cyc - last, 2);
                last = cyc;
                ngr++;
                if (ngr == 8) begin
                    video_req = 0; cpu_req = 0;
                end
            end
        end
        video_req = 0; cpu_req = 0;
        check("contend_grants", ngr, 8);
        repeat (4) @(negedge clk28);
        check("contend_drained", gq.size() + vq.size() + cq.size(), 0);

        // Fixed priority instance: CPU starves while video is requesting
        b_video_req = 1; b_cpu_req = 1; nv = 0; nc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk28);
            if (b_video_ack) nv++;
            if (b_cpu_ack) nc++;
        end
        check("nowait_cpu_starved", nc, 0);
        check("nowait_video_grants", nv, 15);
        b_video_req = 0; got = 0;
        for (int i = 0; i < 6 && got == 0; i++) begin
            @(negedge clk28);
            if (b_cpu_ack) begin
                got = 1; b_cpu_req = 0;
            end
        end
        b_cpu_req = 0;
        check("nowait_cpu_after_video", got, 1);

        // CPU and DMA together
        cpu_addr = 19'h00030; cpu_wr = 0; dma_addr = 19'h00040; dma_wr = 0;
        cpu_req = 1; dma_req = 1;
        gq.push_back(G_CPU); cq.push_back(pat(8'h30));
`ifdef ZX_VRAM_ARB_DMA_EN
        gq.push_back(G_DMA); dq.push_back(pat(8'h40));
`endif
        nd = 0; cpu_at = -1; dma_at = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk28);
            if (cpu_ack) begin
                cpu_at = i; cpu_req = 0;
            end
            if (dma_ack) begin
                dma_at = i; nd++; dma_req = 0;
            end
        end
        dma_req = 0;
        check("dma_cpu_first", cpu_at, 1);
`ifdef ZX_VRAM_ARB_DMA_EN
        check("dma_grant_count", nd, 1);
        check("dma_next_slot", dma_at - cpu_at, 2);
`else
        check("dma_disabled_ack", nd, 0);
        check("dma_disabled_rdata", dma_rdata, 0);
`endif
        repeat (3) @(negedge clk28);
        check("dma_drained", gq.size() + cq.size() + dq.size(), 0);

        // Reset during P1 of a write
        cpu_req = 1; cpu_wr = 1; cpu_addr = 19'h00050; cpu_wdata = 8'h3C;
        gq.push_back(G_CPU);
        @(negedge clk28);
        check("rstw_ack", cpu_ack, 1);
        cpu_req = 0;
        @(negedge clk28);
        check("rstw_p1_nvwr", n_vwr, 0);
        rst = 1;
        @(negedge clk28);
        check("rstw_strobes", {n_vrd, n_vwr, vd_oe}, 3'b110);
        check("rstw_va", va, 0);
        check("rstw_no_valid", cpu_valid, 0);
        rst = 0;
        wr0 = wr_lo;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 19'h00060;
        gq.push_back(G_CPU); cq.push_back(pat(8'h60));
        @(negedge clk28);
        check("post_rst_ack", cpu_ack, 1);
        cpu_req = 0;
        repeat (4) @(negedge clk28);
        check("post_rst_no_wr", wr_lo - wr0, 0);
        check("post_rst_drained", gq.size() + cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
